control_unit: RTL
=================

# control_unit

Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU. It drives the program counter (load/increment), the synchronous memory (address, write enable), the accumulator register load and the ALU opcode. It holds the instruction and operand registers internally. It sits at the top of the CPU datapath, between memory `data_out` and the PC/ALU/accumulator control pins.

## Interface
- No parameters; all widths fixed at 8-bit data/address, 4-bit opcode.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution; sampled only in IDLE.
- `pc_value`  in  8  current PC register output.
- `mem_rdata`  in  8  memory `data_out`; valid the cycle after the address is presented.
- `zero_flag`  in  1  registered ALU zero flag.
- `mem_addr`  out  8  memory address.
- `mem_we`  out  1  memory write enable; the datapath wires accumulator to memory `data_in`.
- `pc_load`, `pc_increment`  out  1  PC strobes; never both high.
- `pc_target`  out  8  PC load value.
- `acc_load`  out  1  accumulator load strobe.
- `acc_src_sel`  out  1  0 = ALU result, 1 = `mem_rdata`.
- `alu_op`  out  4  ALU operation; the ALU's b input is `mem_rdata`.
- `halted`  out  1  high in HALT.
- `state`  out  3  debug state code.

## Operation
- Instruction byte: opcode = [7:4]; [3:0] is ignored. Two-byte instructions take their operand from the next byte.
- Opcodes: 0 NOP, 1 LDA a, 2 STA a, 3 ADD a, 4 SUB a, 5 AND a, 6 OR a, 7 XOR a, 8 JMP a, 9 JZ a, A LDI imm, F HLT. Opcodes B–E execute as NOP.
- States and codes: IDLE=0, FETCH=1, DECODE=2, OPERAND=3, EXECUTE=4, WRITEBACK=5, HALT=6.
- IDLE: all strobes 0. Moves to FETCH when `start`=1.
- FETCH: `mem_addr`=`pc_value`, `pc_increment`=1. Moves to DECODE.
- DECODE: `ir`<=`mem_rdata[7:4]`.
  - NOP/undefined opcode: moves to FETCH.
  - HLT: moves to HALT.
  - Otherwise: `mem_addr`=`pc_value`, `pc_increment`=1, moves to OPERAND.
- OPERAND: `opr`<=`mem_rdata`.
  - LDI: `acc_load`=1, `acc_src_sel`=1, then FETCH.
  - JMP: `pc_load`=1, `pc_target`=`mem_rdata`, then FETCH.
  - JZ: same as JMP, gated by `zero_flag`, then FETCH.
  - LDA, STA, ALU ops: move to EXECUTE.
- EXECUTE: `mem_addr`=`opr`.
  - STA: `mem_we`=1, then FETCH.
  - Others: move to WRITEBACK.
- WRITEBACK: `acc_load`=1.
  - LDA: `acc_src_sel`=1.
  - ADD..XOR: `acc_src_sel`=0, `alu_op` per package code.
  - Moves to FETCH.
- HALT: `halted`=1, all strobes 0. Sticky until reset; `start` is ignored.
- Outputs are combinational from `state`, `ir`, `opr`, `mem_rdata` and `zero_flag`. `mem_addr` defaults to `pc_value` and `alu_op` defaults to ADD when unused.

## Timing
- Cycles per instruction: NOP/HLT/undefined 2; LDI/JMP/JZ 3; STA 4; LDA/ADD..XOR 5.
- PC wraps 0xFF→0x00; the controller does no range checking.
- JZ samples `zero_flag` in OPERAND. The flag reflects the last ALU writeback.
- Reset value of every output: 0, except `state`=0 (IDLE). `ir` and `opr` reset to 0.
- Reset asserted mid-instruction: `mem_we`/`acc_load`/`pc_*` drop immediately (asynchronously) and the state returns to IDLE. A partially executed instruction has no further effect.
- `start` held high through IDLE→FETCH is harmless, since it is ignored outside IDLE.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_NOP..OP_HLT);
  - ALU op codes (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4);
  - state encoding constants.
- One natural sub-module, `opcode_decoder`: combinational opcode → {two_byte, is_mem_read, is_store, is_alu, alu_op} decode, reused by the disassembler/trace monitor.

## Test plan
- Reset then `start`; memory 0x00:A0 05, 0x02:30 10, 0x10:03 → accumulator 0x08 after 8 cycles from first FETCH; PC=0x04.
- STA: accumulator 0x5A, memory 0x00:20 40 → `mem_we` high exactly one cycle, in EXECUTE, with `mem_addr`=0x40; 4 cycles total.
- JZ taken and not taken: `zero_flag`=1 with 0x00:90 20 → PC=0x20; `zero_flag`=0 → PC=0x02.
- Opcode 0xC0 then HLT (0xF0) → undefined opcode takes 2 cycles with no strobes; then `halted`=1 with all strobes 0 for 20 cycles despite `start` pulses.
- Reset asserted during STA EXECUTE → `mem_we` falls before the next clock edge, `state`=0, memory unchanged.
- PC at 0xFE executing JMP 0x00 → operand fetched from 0xFF, PC loads 0x00, next FETCH `mem_addr`=0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, ALU codes,
// and the sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_OPERAND   = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

endpackage

// File: rtl/opcode_decoder.sv
// Pure combinational opcode classification, shared with trace/disassembly tools.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       two_byte,
  output logic       is_mem_read,
  output logic       is_store,
  output logic       is_alu,
  output logic [3:0] alu_op
);

  // Opcode to instruction-class lookup; B..E fall through as one-byte NOPs
  always_comb begin
    two_byte    = 1'b0;
    is_mem_read = 1'b0;
    is_store    = 1'b0;
    is_alu      = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OP_LDA: begin two_byte = 1'b1; is_mem_read = 1'b1; end
      OP_STA: begin two_byte = 1'b1; is_store = 1'b1; end
      OP_ADD: begin two_byte = 1'b1; is_mem_read = 1'b1; is_alu = 1'b1; alu_op = ALU_ADD; end
      OP_SUB: begin two_byte = 1'b1; is_mem_read = 1'b1; is_alu = 1'b1; alu_op = ALU_SUB; end
      OP_AND: begin two_byte = 1'b1; is_mem_read = 1'b1; is_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:  begin two_byte = 1'b1; is_mem_read = 1'b1; is_alu = 1'b1; alu_op = ALU_OR;  end
      OP_XOR: begin two_byte = 1'b1; is_mem_read = 1'b1; is_alu = 1'b1; alu_op = ALU_XOR; end
      OP_JMP, OP_JZ, OP_LDI: two_byte = 1'b1;
      default: two_byte = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Control outputs decode combinationally from the registered state/ir/opr.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pc_value,
  input  logic [7:0] mem_rdata,
  input  logic       zero_flag,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic       pc_load,
  output logic       pc_increment,
  output logic [7:0] pc_target,
  output logic       acc_load,
  output logic       acc_src_sel,
  output logic [3:0] alu_op,
  output logic       halted,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [3:0] ir_q, ir_d;
  logic [7:0] opr_q, opr_d;

  logic [3:0] dec_opcode;
  logic       dec_two_byte, dec_mem_read, dec_store, dec_alu;
  logic [3:0] dec_alu_op;

  // In DECODE the opcode is still on the memory bus; afterwards it lives in ir
  assign dec_opcode = (state_q == ST_DECODE) ? mem_rdata[7:4] : ir_q;

  opcode_decoder u_dec (
    .opcode      (dec_opcode),
    .two_byte    (dec_two_byte),
    .is_mem_read (dec_mem_read),
    .is_store    (dec_store),
    .is_alu      (dec_alu),
    .alu_op      (dec_alu_op)
  );

  assign state = state_q;

  // Next-state, register updates and control strobes
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    opr_d        = opr_q;
    mem_addr     = pc_value;
    mem_we       = 1'b0;
    pc_load      = 1'b0;
    pc_increment = 1'b0;
    pc_target    = 8'h00;
    acc_load     = 1'b0;
    acc_src_sel  = 1'b0;
    alu_op       = ALU_ADD;
    halted       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        pc_increment = 1'b1;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d = mem_rdata[7:4];
        if (mem_rdata[7:4] == OP_HLT) begin
          state_d = ST_HALT;
        end else if (dec_two_byte) begin
          pc_increment = 1'b1;
          state_d      = ST_OPERAND;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_OPERAND: begin
        opr_d = mem_rdata;
        if (dec_mem_read || dec_store) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_FETCH;
          case (ir_q)
            OP_LDI: begin acc_load = 1'b1; acc_src_sel = 1'b1; end
            OP_JMP: begin pc_load = 1'b1; pc_target = mem_rdata; end
            OP_JZ:  begin pc_load = zero_flag; pc_target = mem_rdata; end
            default: pc_load = 1'b0;
          endcase
        end
      end
      ST_EXECUTE: begin
        mem_addr = opr_q;
        if (dec_store) begin
          mem_we  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        acc_load = 1'b1;
        if (dec_alu) begin
          acc_src_sel = 1'b0;
          alu_op      = dec_alu_op;
        end else begin
          acc_src_sel = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and instruction/operand holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ir_q    <= 4'h0;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

endmodule
